// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the control-state encoding, the buffered entry layout and default constants.
// Imported by the fetch buffer, the handshake interface users and the top.
package fetch_sequencer_pkg;

    // Fetch control state: RUN fetches, DRAIN empties the buffer after the
    // end-of-program word was seen, HALTED is terminal until reset.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // One fetch buffer slot: byte address of the instruction and the word itself.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    // Instruction memory is word addressed; the low two address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between fetch sequencer, instruction memory and decode.
// No latency of its own; plain wires.
// Decode backpressures through out_ready; memory read is combinational.
interface fetch_sequencer_if;

    // instruction memory side
    logic [31:0] im_addr;
    logic [31:0] im_data;

    // branch/jump redirect from execute
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // decode side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    // sequencer side of the bundle
    modport master (
        output im_addr,
        input  im_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    // environment side: memory, redirect source and decode
    modport slave (
        input  im_addr,
        output im_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} with push, pop and single-cycle flush.
// Latency: pushed entry is at the head the cycle after the push; head read is combinational.
// Backpressure: caller must not push when full unless popping in the same cycle, nor pop when empty.
module fetch_fifo
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fetch_entry_t  push_dat_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_dat_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Control registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: a slot is only observed after it was written.
    // When full with a simultaneous pop, the write lands in the slot being read out
    // this cycle, which is safe because the head is consumed on the same edge.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, fetches one word per cycle into a small buffer and hands {pc, instr} to decode.
// Latency: word fetched in cycle N is on out_* in cycle N+1; one fetch per cycle sustained.
// Backpressure: fetch stalls while the buffer is full and decode is not popping; out_* held stable.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_sequencer_if.master      bus,
    output logic                   halted,
    output logic                   misalign_err,
    output logic [31:0]            fetch_count
);

    localparam int            CW      = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e        state_q, state_d;
    logic [31:0]   pc_q,    pc_d;
    logic [31:0]   fc_q,    fc_d;
    logic          mis_q,   mis_d;

    fetch_entry_t  head_dat;
    fetch_entry_t  push_dat;
    logic [CW-1:0] fifo_count;

    logic          head_vld;
    logic          redirect_eff;
    logic          pop_req;
    logic          fifo_pop;
    logic          room;
    logic          fetch_try;
    logic          sentinel;
    logic          push;

    // Handshake qualification: redirects are dead once halted, and a flush
    // discards the head, so a pop coinciding with a redirect is not a delivery.
    always_comb begin
        head_vld     = (fifo_count != '0) && (state_q != ST_HALTED);
        redirect_eff = bus.redirect_valid && (state_q != ST_HALTED);
        pop_req      = head_vld && bus.out_ready;
        fifo_pop     = pop_req && !redirect_eff;
        room         = (fifo_count < DEPTH_C) || pop_req;
        fetch_try    = (state_q == ST_RUN) && room && !redirect_eff;
        sentinel     = (bus.im_data == HALT_WORD);
        push         = fetch_try && !sentinel;
        push_dat     = '{pc: pc_q, instr: bus.im_data};
    end

    // Next control state; a redirect always returns to RUN because any
    // sentinel seen before it was fetched down a wrong path.
    always_comb begin
        state_d = state_q;
        if (redirect_eff) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (fetch_try && sentinel) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_count == '0) begin
                        state_d = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // PC, fetch counter and sticky misalignment flag.
    // The sentinel leaves the PC on itself so im_addr points at the last word read.
    always_comb begin
        pc_d  = pc_q;
        fc_d  = fc_q;
        mis_d = mis_q;
        if (redirect_eff) begin
            pc_d = word_align(bus.redirect_pc);
            if (bus.redirect_pc[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end
        end else if (push) begin
            pc_d = pc_q + 32'd4;
            fc_d = fc_q + 32'd1;
        end
    end

    // State registers, all discarded immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            fc_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fc_q    <= fc_d;
            mis_q   <= mis_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (fifo_pop),
        .flush_i    (redirect_eff),
        .head_dat_o (head_dat),
        .count_o    (fifo_count)
    );

    // Outputs read as zero while the buffer is empty so decode never sees stale data.
    assign bus.im_addr   = pc_q;
    assign bus.out_valid = head_vld;
    assign bus.out_pc    = head_vld ? head_dat.pc    : 32'h0;
    assign bus.out_instr = head_vld ? head_dat.instr : 32'h0;
    assign halted        = (state_q == ST_HALTED);
    assign misalign_err  = mis_q;
    assign fetch_count   = fc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed scenarios followed by randomized traffic against a queue model.
// Model advances once per clock edge; outputs are sampled 1 time unit after the rising edge.
// Inputs are driven at the same point, well away from the active edge.
module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int          DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rp = 32'h0;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    // reference model state
    ent_t        m_q [$];
    logic [31:0] m_pc;
    int          m_mode;     // 0 fetching, 1 draining, 2 halted
    logic [31:0] m_fc;
    logic        m_mis;

    fetch_sequencer_if bus ();

    assign bus.im_data        = mem[bus.im_addr[9:2]];
    assign bus.redirect_valid = rv;
    assign bus.redirect_pc    = rp;
    assign bus.out_ready      = rdy;

    fetch_sequencer #(
        .RESET_PC  (32'h0),
        .DEPTH     (DEPTH),
        .HALT_WORD (HALT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .halted       (halted),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = 32'h0;
        m_mode = 0;
        m_fc   = 32'h0;
        m_mis  = 1'b0;
    endtask

    // One clock edge worth of program-level behaviour, from the current inputs.
    task automatic model_step();
        int          sz0;
        bit          pop;
        logic [31:0] w;
        if (m_mode != 2 && rv) begin
            m_q.delete();
            m_pc = rp & ~32'h3;
            if (rp[1:0] != 2'b00) m_mis = 1'b1;
            m_mode = 0;
        end else begin
            sz0 = m_q.size();
            pop = (sz0 > 0) && rdy;
            w   = mem[m_pc[9:2]];
            if (pop) void'(m_q.pop_front());
            if (m_mode == 0 && (sz0 < DEPTH || pop)) begin
                if (w == HALT) begin
                    m_mode = 1;
                end else begin
                    m_q.push_back('{pc: m_pc, instr: w});
                    m_pc = m_pc + 32'd4;
                    m_fc = m_fc + 32'd1;
                end
            end else if (m_mode == 1 && sz0 == 0) begin
                m_mode = 2;
            end
        end
    endtask

    task automatic check_all();
        bit v;
        v = (m_q.size() != 0);
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, v});
        chk("out_pc",    bus.out_pc,    v ? m_q[0].pc    : 32'h0);
        chk("out_instr", bus.out_instr, v ? m_q[0].instr : 32'h0);
        chk("im_addr",   bus.im_addr,   m_pc);
        chk("halted",    {31'b0, halted}, {31'b0, m_mode == 2});
        chk("misalign",  {31'b0, misalign_err}, {31'b0, m_mis});
        chk("fetch_cnt", fetch_count,   m_fc);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Assert reset away from the edge, check reset values, release after one edge.
    task automatic do_reset();
        rst_n = 1'b0;
        rv    = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 256; i++) mem[i] = 32'h1300_0000 | i;
    endtask

    initial begin
        fill_linear();

        // straight line to the sentinel with decode always ready
        do_reset();
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_addr",  bus.im_addr, 32'h0);
        mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC; mem[3] = 32'hD; mem[4] = HALT;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sl_pc", bus.out_pc, 32'(i * 4));
        end
        chk("sl_instr_d", bus.out_instr, 32'hD);
        step();
        chk("sl_halt5", {31'b0, halted}, 32'd0);
        step();
        chk("sl_halt6", {31'b0, halted}, 32'd1);
        chk("sl_fcnt",  fetch_count, 32'd4);
        // redirects are ignored once halted
        rv = 1'b1; rp = 32'h40;
        step();
        rv = 1'b0;
        chk("halt_ign", bus.im_addr, 32'h10);
        chk("halt_stay", {31'b0, halted}, 32'd1);

        // backpressure: buffer fills to two entries and holds
        fill_linear();
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp_pc",    bus.out_pc, 32'h0);
        end
        chk("bp_addr", bus.im_addr, 32'h8);
        rdy = 1'b1;
        step();
        chk("bp_rel1", bus.out_pc, 32'h4);
        step();
        chk("bp_rel2", bus.out_pc, 32'h8);

        // redirect with two entries buffered
        do_reset();
        rdy = 1'b0;
        step();
        step();
        rv = 1'b1; rp = 32'h40;
        step();
        chk("rd_flush", {31'b0, bus.out_valid}, 32'd0);
        chk("rd_addr",  bus.im_addr, 32'h40);
        rv = 1'b0; rdy = 1'b1;
        step();
        chk("rd_first", bus.out_pc, 32'h40);

        // sentinel on a wrong path, redirected while draining
        do_reset();
        mem[4] = HALT;
        rdy = 1'b1;
        repeat (4) step();
        rdy = 1'b0;
        step();
        chk("wp_addr",  bus.im_addr, 32'h10);
        chk("wp_nohlt", {31'b0, halted}, 32'd0);
        rv = 1'b1; rp = 32'h20;
        step();
        chk("wp_redir", bus.im_addr, 32'h20);
        rv = 1'b0; rdy = 1'b1;
        step();
        chk("wp_resume", bus.out_pc, 32'h20);
        repeat (2) step();
        chk("wp_run", {31'b0, halted}, 32'd0);

        // misaligned redirect target
        rv = 1'b1; rp = 32'h43;
        step();
        chk("mis_addr", bus.im_addr, 32'h40);
        chk("mis_set",  {31'b0, misalign_err}, 32'd1);
        rv = 1'b0;
        repeat (3) step();
        chk("mis_sticky", {31'b0, misalign_err}, 32'd1);

        // asynchronous reset mid-run, observed before any clock edge
        fill_linear();
        do_reset();
        rdy = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("ar_addr",  bus.im_addr, 32'h0);
        chk("ar_fcnt",  fetch_count, 32'h0);
        chk("ar_mis",   {31'b0, misalign_err}, 32'd0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 19) == 0) w = HALT;
            else if (w == HALT) w = 32'h0;
            mem[i] = w;
        end
        do_reset();
        begin
            int halted_cycles = 0;
            for (int c = 0; c < 3000; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                rv  = ($urandom_range(0, 15) == 0);
                rp  = 32'($urandom_range(0, 255)) << 2;
                if ($urandom_range(0, 7) == 0) rp[1:0] = 2'($urandom_range(0, 3));
                step();
                if (m_mode == 2) halted_cycles++;
                if (halted_cycles > 3) begin
                    halted_cycles = 0;
                    do_reset();
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
